// File: rtl/spi_pkg.sv
// spi_pkg: SPI state encoding and mode decode.
// Shared with the receive stage so both derive edges identically.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP,
    HOLD
  } spi_tx_state_t;

  function automatic logic spi_cpol(input int mode);
    return (mode >= 2);
  endfunction

  function automatic logic spi_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter, 0..PRESCALE-1.
// o_tick marks the last cycle of each half-period.
module spi_clk_div #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == TOP);

  always_ff @(posedge clk) begin
    if (rst || i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: AXI-Stream to SPI master transmit stage.
// Define SPI_MASTER_TX_TLAST_EN for multi-word cs_n frames.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SPI_MODE   = 0,
  parameter int PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
`ifdef SPI_MASTER_TX_TLAST_EN
  input  logic                  s_axis_tlast,
`endif
  output logic                  s_axis_tready,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  busy
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);
  localparam int   HW   = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [HW-1:0] LAST_H = HW'(2 * DATA_WIDTH - 1);

  spi_tx_state_t         r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [HW-1:0]         r_hcnt;
  logic                  r_tready;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_mosi;
  logic                  r_busy;

  logic                  w_tick;
  logic                  w_clr;
  logic                  w_acc;
  logic                  w_lead;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_shl;

`ifdef SPI_MASTER_TX_TLAST_EN
  logic r_last;
  logic r_wait;
  assign w_clr = (r_state == IDLE) ||
                 ((r_state == HOLD) && !r_wait);
`else
  assign w_clr = (r_state == IDLE);
`endif

  assign w_acc  = s_axis_tvalid && r_tready;
  assign w_lead = ~r_hcnt[0];
  assign w_last = (r_hcnt == LAST_H);
  assign w_shl  = {r_shreg[DATA_WIDTH-2:0], 1'b0};

  // CPHA=0 presents the MSB at load, so the register starts pre-shifted
  assign w_load = CPHA ? s_axis_tdata
                       : {s_axis_tdata[DATA_WIDTH-2:0], 1'b0};

  spi_clk_div #(
    .PRESCALE (PRESCALE)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_hcnt   <= '0;
      r_tready <= 1'b0;
      r_sclk   <= CPOL;
      r_cs_n   <= 1'b1;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef SPI_MASTER_TX_TLAST_EN
      r_last   <= 1'b0;
      r_wait   <= 1'b0;
`endif
    end else begin
      r_tready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tready <= ~w_acc;
          if (w_acc) begin
            r_state <= LEAD;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_shreg <= w_load;
            if (!CPHA) r_mosi <= s_axis_tdata[DATA_WIDTH-1];
`ifdef SPI_MASTER_TX_TLAST_EN
            r_last  <= s_axis_tlast;
`endif
          end
        end
        LEAD: begin
          if (w_tick) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if ((w_lead == CPHA) && !w_last) begin
              r_mosi  <= r_shreg[DATA_WIDTH-1];
              r_shreg <= w_shl;
            end
            if (w_last) begin
              r_hcnt  <= '0;
              r_state <= TRAIL;
`ifdef SPI_MASTER_TX_TLAST_EN
              if (!r_last) begin
                r_state  <= HOLD;
                r_tready <= 1'b1;
              end
`endif
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end
        TRAIL: begin
          if (w_tick) begin
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
`ifdef SPI_MASTER_TX_TLAST_EN
        HOLD: begin
          if (r_wait) begin
            if (w_tick) begin
              r_wait  <= 1'b0;
              r_state <= SHIFT;
            end
          end else begin
            r_tready <= ~w_acc;
            if (w_acc) begin
              r_wait  <= 1'b1;
              r_shreg <= w_load;
              r_last  <= s_axis_tlast;
              if (!CPHA) r_mosi <= s_axis_tdata[DATA_WIDTH-1];
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign sclk          = r_sclk;
  assign cs_n          = r_cs_n;
  assign mosi          = r_mosi;
  assign busy          = r_busy;

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed bench over four mode/prescale variants.
// Bit capture follows the receiver's sample edge for each mode.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0][7:0] tdata;
  logic [3:0] tvalid;
  logic [3:0] tready;
  logic [3:0] sclk;
  logic [3:0] cs_n;
  logic [3:0] mosi;
  logic [3:0] busy;
`ifdef SPI_MASTER_TX_TLAST_EN
  logic tlast = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int gap;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_WIDTH(8), .SPI_MODE(0), .PRESCALE(2)) u_m0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
`ifdef SPI_MASTER_TX_TLAST_EN
    .s_axis_tlast(tlast),
`endif
    .s_axis_tready(tready[0]), .sclk(sclk[0]), .cs_n(cs_n[0]),
    .mosi(mosi[0]), .busy(busy[0]));

  spi_master_tx #(.DATA_WIDTH(8), .SPI_MODE(1), .PRESCALE(2)) u_m1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
`ifdef SPI_MASTER_TX_TLAST_EN
    .s_axis_tlast(1'b1),
`endif
    .s_axis_tready(tready[1]), .sclk(sclk[1]), .cs_n(cs_n[1]),
    .mosi(mosi[1]), .busy(busy[1]));

  spi_master_tx #(.DATA_WIDTH(8), .SPI_MODE(2), .PRESCALE(2)) u_m2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
`ifdef SPI_MASTER_TX_TLAST_EN
    .s_axis_tlast(1'b1),
`endif
    .s_axis_tready(tready[2]), .sclk(sclk[2]), .cs_n(cs_n[2]),
    .mosi(mosi[2]), .busy(busy[2]));

  spi_master_tx #(.DATA_WIDTH(8), .SPI_MODE(3), .PRESCALE(1)) u_m3 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
`ifdef SPI_MASTER_TX_TLAST_EN
    .s_axis_tlast(1'b1),
`endif
    .s_axis_tready(tready[3]), .sclk(sclk[3]), .cs_n(cs_n[3]),
    .mosi(mosi[3]), .busy(busy[3]));

  task automatic frame(input int d, input logic [7:0] w,
                       input bit keep, input logic [7:0] nxt,
                       input int exp_low, input bit smp_rise,
                       input string nm);
    int low = 0;
    int edges = 0;
    logic [7:0] rx = '0;
    logic ps;
    logic pm;
    bit seen = 0;
    bit bad = 0;
    bit rbad = 0;
    bit acc = 0;
    tdata[d] = w;
    tvalid[d] = 1'b1;
    gap = 0;
    for (int c = 0; c < 200; c++) begin
      if (tready[d]) begin
        acc = 1;
        break;
      end
      if (cs_n[d]) gap++;
      @(negedge clk);
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL %s accept: tready=0 want 1", nm);
      tvalid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (keep) tdata[d] = nxt;
    else tvalid[d] = 1'b0;
    ps = sclk[d];
    pm = mosi[d];
    for (int c = 0; c < 400; c++) begin
      if (!cs_n[d]) begin
        seen = 1;
        low++;
        if (tready[d] || !busy[d]) rbad = 1;
        if (sclk[d] !== ps && sclk[d] === smp_rise) begin
          rx = {rx[6:0], mosi[d]};
          edges++;
          if (mosi[d] !== pm) bad = 1;
        end else if (sclk[d] === ps && mosi[d] !== pm) begin
          bad = 1;
        end
      end else if (seen) begin
        break;
      end
      ps = sclk[d];
      pm = mosi[d];
      @(negedge clk);
    end
    vectors++;
    if (rx !== w) begin
      miscompares++;
      $display("FAIL %s data: got %h want %h", nm, rx, w);
    end
    vectors++;
    if (low != exp_low) begin
      miscompares++;
      $display("FAIL %s cs_low: got %0d want %0d", nm, low, exp_low);
    end
    vectors++;
    if (edges != 8) begin
      miscompares++;
      $display("FAIL %s edges: got %0d want 8", nm, edges);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s mosi_timing: got unstable want stable", nm);
    end
    vectors++;
    if (rbad) begin
      miscompares++;
      $display("FAIL %s ready_busy: got tready=1/busy=0 in frame want 0/1",
               nm);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (tready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_tready: got %b want 0000", tready);
    end
    vectors++;
    if (cs_n !== 4'b1111) begin
      miscompares++;
      $display("FAIL rst_cs_n: got %b want 1111", cs_n);
    end
    vectors++;
    if (sclk !== 4'b1100) begin
      miscompares++;
      $display("FAIL rst_sclk: got %b want 1100", sclk);
    end
    vectors++;
    if (mosi !== 4'b0000 || busy !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mosi_busy: got %b/%b want 0000/0000", mosi, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (tready !== 4'b1111) begin
      miscompares++;
      $display("FAIL rst_release_tready: got %b want 1111", tready);
    end
  endtask

  task automatic test_mode0;
    frame(0, 8'hA5, 1'b0, 8'h00, 36, 1'b1, "mode0_a5");
  endtask

  task automatic test_mode3;
    frame(3, 8'h3C, 1'b0, 8'h00, 18, 1'b1, "mode3_3c");
  endtask

  task automatic test_modes12;
    frame(1, 8'h81, 1'b0, 8'h00, 36, 1'b0, "mode1_81");
    frame(2, 8'h81, 1'b0, 8'h00, 36, 1'b0, "mode2_81");
  endtask

  task automatic test_back_to_back;
    frame(0, 8'h11, 1'b1, 8'h22, 36, 1'b1, "b2b_w0");
    frame(0, 8'h22, 1'b0, 8'h00, 36, 1'b1, "b2b_w1");
    vectors++;
    if (gap != 3) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d want 3", gap);
    end
  endtask

  task automatic test_reset_abort;
    int n = 0;
    logic ps;
    tdata[0] = 8'hFF;
    tvalid[0] = 1'b1;
    for (int c = 0; c < 200 && !tready[0]; c++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    tvalid[0] = 1'b0;
    ps = sclk[0];
    for (int c = 0; c < 200; c++) begin
      if (sclk[0] !== ps) begin
        n++;
        if (n == 3) break;
      end
      ps = sclk[0];
      @(negedge clk);
    end
    vectors++;
    if (n != 3 || cs_n[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pre: got edges=%0d cs_n=%b want 3/0",
               n, cs_n[0]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({cs_n[0], sclk[0], busy[0], mosi[0]} !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_state: got cs/sclk/busy/mosi=%b want 1000",
               {cs_n[0], sclk[0], busy[0], mosi[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (tready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_tready: got %b want 1", tready[0]);
    end
    @(negedge clk);
    frame(0, 8'h5A, 1'b0, 8'h00, 36, 1'b1, "abort_next_5a");
  endtask

`ifdef SPI_MASTER_TX_TLAST_EN
  task automatic test_tlast;
    logic [7:0] wv [3];
    int idx = 0;
    int edges = 0;
    logic [23:0] rx = '0;
    bit pend = 0;
    bit seen = 0;
    bit rose = 0;
    logic ps;
    wv = '{8'hDE, 8'hAD, 8'hBE};
    tdata[0] = wv[0];
    tlast = 1'b0;
    tvalid[0] = 1'b1;
    ps = sclk[0];
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        idx++;
        if (idx < 3) begin
          tdata[0] = wv[idx];
          tlast = (idx == 2);
        end else begin
          tvalid[0] = 1'b0;
        end
      end
      if (tvalid[0] && tready[0]) pend = 1;
      if (!cs_n[0]) begin
        seen = 1;
      end else if (seen) begin
        rose = 1;
        break;
      end
      if (sclk[0] !== ps && sclk[0] === 1'b1) begin
        rx = {rx[22:0], mosi[0]};
        edges++;
      end
      ps = sclk[0];
    end
    vectors++;
    if (!rose || idx != 3) begin
      miscompares++;
      $display("FAIL tlast_frame: got rose=%0d words=%0d want 1/3",
               rose, idx);
    end
    vectors++;
    if (edges != 24) begin
      miscompares++;
      $display("FAIL tlast_edges: got %0d want 24", edges);
    end
    vectors++;
    if (rx !== 24'hDEADBE) begin
      miscompares++;
      $display("FAIL tlast_data: got %h want deadbe", rx);
    end
  endtask
`endif

  initial begin
    tdata = '0;
    tvalid = '0;
    test_reset();
    test_mode0();
    test_mode3();
    test_modes12();
    test_back_to_back();
    test_reset_abort();
`ifdef SPI_MASTER_TX_TLAST_EN
    test_tlast();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
